// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared encodings for the LED status controller.
// Contents: requester display modes, the all-off LED drive value, FSM state enum.
// Optional feature macro used by the controller: LED_PWM_EN (no effect here).
package led_ctrl_pkg;

  localparam logic [1:0] MODE_SOLID = 2'b00;
  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_FLASH = 2'b10;

  // LEDs are active-low, so all ones means dark
  localparam logic [3:0] LED_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/led_status_ctrl_if.sv
// led_status_ctrl_if: request bus from N_REQ status sources into the LED controller.
// Signals: req_valid/req_pattern/req_mode (requesters -> controller),
//   grant/led_n/busy (controller -> observers); brightness added when LED_PWM_EN is defined.
interface led_status_ctrl_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [4*N_REQ-1:0] req_pattern;
  logic [2*N_REQ-1:0] req_mode;
  logic [N_REQ-1:0]   grant;
  logic [3:0]         led_n;
  logic               busy;

`ifdef LED_PWM_EN
  logic [3:0] brightness;

  modport master (output req_valid, req_pattern, req_mode, brightness,
                  input  grant, led_n, busy);
  modport slave  (input  req_valid, req_pattern, req_mode, brightness,
                  output grant, led_n, busy);
`else
  modport master (output req_valid, req_pattern, req_mode,
                  input  grant, led_n, busy);
  modport slave  (input  req_valid, req_pattern, req_mode,
                  output grant, led_n, busy);
`endif
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: free-running prescaler, one-clk tick every TICK_DIV clocks.
// Ports: clk, rst (async, active-high), tick (high on the last count before wrap).
// Only rst clears the count; grants never realign it.
module led_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/led_status_ctrl.sv
// led_status_ctrl: single owner of the 4 active-low board LEDs, shared by N_REQ requesters
// with fixed priority (0 highest), minimum hold before preemption, solid/blink/one-shot modes.
// Ports: clk, rst (async, active-high); bus (slave modport): req_* in, grant/led_n/busy out.
// Macro LED_PWM_EN adds bus.brightness and a 4-bit PWM gate on lit LEDs.
module led_status_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TICK_DIV       = 100000,
  parameter int BLINK_TICKS    = 250,
  parameter int MIN_HOLD_TICKS = 500
) (
  input  logic             clk,
  input  logic             rst,
  led_status_ctrl_if.slave bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (MIN_HOLD_TICKS > 0) ? $clog2(MIN_HOLD_TICKS + 1) : 1;
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic tick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic [BW-1:0]    flash_q, flash_d;
  logic             phase_q, phase_d;
  logic [N_REQ-1:0] spent_q, spent_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [3:0]       led_q, led_d;
  logic             busy_q;

  logic [N_REQ-1:0] avail;
  logic             pick_vld, hi_vld;
  logic [OW-1:0]    pick_idx, hi_idx;
  logic             pwm_on;

  // Spent one-shot requesters sit out arbitration until they drop valid.
  assign avail = bus.req_valid & ~spent_q;

  // Lowest set index wins; hi_* only considers indices above the owner in priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    hi_vld   = 1'b0;
    hi_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(i);
      end
      if (avail[i] && (OW'(i) < owner_q)) begin
        hi_vld = 1'b1;
        hi_idx = OW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    flash_d = flash_q;
    phase_d = phase_q;
    spent_d = spent_q & bus.req_valid;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          owner_d = pick_idx;
          hold_d  = '0;
          blink_d = '0;
          flash_d = '0;
          phase_d = 1'b1;
        end
      end
      OWN: begin
        // A dropping owner always goes through IDLE, even if a preemptor is waiting.
        if (!bus.req_valid[owner_q]) begin
          state_d = IDLE;
        end else if (hi_vld && (hold_q >= HOLD_MAX)) begin
          owner_d = hi_idx;
          hold_d  = '0;
          blink_d = '0;
          flash_d = '0;
          phase_d = 1'b1;
        end else if (tick) begin
          if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
          // Blink phase runs in every mode so a mid-grant mode switch keeps its rhythm.
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
          if (bus.req_mode[2*int'(owner_q) +: 2] == MODE_FLASH) begin
            if (flash_q == BLINK_LAST) begin
              state_d          = DONE;
              spent_d[owner_q] = 1'b1;
            end else begin
              flash_d = flash_q + 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (pwm_cnt < bus.brightness);
`else
  assign pwm_on = 1'b1;
`endif

  // Outputs are built from the next state and the live pattern/mode, then registered.
  always_comb begin
    logic [3:0] pat;
    logic [1:0] mode;
    logic [3:0] lit;
    pat     = bus.req_pattern[4*int'(owner_d) +: 4];
    mode    = bus.req_mode[2*int'(owner_d) +: 2];
    lit     = 4'b0000;
    grant_d = '0;
    if (state_d == OWN) begin
      grant_d[owner_d] = 1'b1;
      lit = (mode == MODE_BLINK && !phase_d) ? 4'b0000 : pat;
    end
    led_d = pwm_on ? ~lit : LED_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      hold_q  <= '0;
      blink_q <= '0;
      flash_q <= '0;
      phase_q <= 1'b0;
      spent_q <= '0;
      grant_q <= '0;
      led_q   <= LED_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      flash_q <= flash_d;
      phase_q <= phase_d;
      spent_q <= spent_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= |grant_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led_n = led_q;
  assign bus.busy  = busy_q;
endmodule
